// File: rtl/key_expand_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..LAST_ROUND one per
// accepted valid/ready handshake, expanding the previous key in place.
module key_expand_iter #(
   parameter int unsigned LAST_ROUND = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_ready,
   output logic         key_valid,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         last_round,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] LAST_IDX = 4'(LAST_ROUND);

   // FIPS-197 forward S-box, index 0 is the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t        state;
   logic [7:0]    rc;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   rot, sub, t;
   logic [31:0]   n0, n1, n2, n3;
   logic [127:0]  next_key;

   // Round constant for the key being produced next (round_idx + 1).
   always_comb begin
      rc = 8'h00;
      case (round_idx + 4'd1)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
   end

   // One AES-128 key expansion step on the current round key.
   always_comb begin
      {w0, w1, w2, w3} = round_key;
      rot      = {w3[23:0], w3[31:24]};
      sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
      t        = sub ^ {rc, 24'h000000};
      n0       = w0 ^ t;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // Schedule control: load on start in IDLE, advance on each accept in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_valid <= 1'b0;
         round_key <= '0;
         round_idx <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  round_key <= key_in;
                  round_idx <= '0;
                  key_valid <= 1'b1;
               end
            end
            RUN: begin
               if (key_valid && key_ready) begin
                  if (round_idx == LAST_IDX) begin
                     state     <= IDLE;
                     key_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     round_key <= next_key;
                     round_idx <= round_idx + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy       = (state == RUN);
   assign last_round = key_valid && (round_idx == LAST_IDX);

endmodule
